// File: rtl/axis_cfg_writer.sv
// AXI-Stream slave that writes (index, value) word pairs into a bank of CFG_NUM config registers.
// Optional macro AXIS_CFG_WRITER_STROBE_EN adds the per-register write strobe output cfg_strb.
module axis_cfg_writer #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CFG_NUM          = 4,
   parameter int ERR_CNTR_WIDTH   = 16
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic [AXIS_TDATA_WIDTH-1:0]           s_axis_tdata,
   input  logic                                  s_axis_tvalid,
   input  logic                                  s_axis_tlast,
   output logic                                  s_axis_tready,
   output logic [CFG_NUM*AXIS_TDATA_WIDTH-1:0]   cfg_data,
   output logic [ERR_CNTR_WIDTH-1:0]             sts_err
`ifdef AXIS_CFG_WRITER_STROBE_EN
   ,
   output logic [CFG_NUM-1:0]                    cfg_strb
`endif
);

   localparam int W  = AXIS_TDATA_WIDTH;
   // Widened so the index compare sees the full word and CFG_NUM up to 256 fits.
   localparam int CW = AXIS_TDATA_WIDTH + 9;

   typedef enum logic {ST_ADDR = 1'b0, ST_DATA = 1'b1} state_t;

   state_t          state;
   logic [W-1:0]    idx;
   logic [CW-1:0]   idx_ext;
   logic            beat;
   logic            in_range;

   assign beat     = s_axis_tvalid & s_axis_tready;
   assign idx_ext  = CW'(idx);
   assign in_range = idx_ext < CW'(CFG_NUM);

   function automatic logic [ERR_CNTR_WIDTH-1:0] sat_inc(input logic [ERR_CNTR_WIDTH-1:0] c);
      return (&c) ? c : c + ERR_CNTR_WIDTH'(1);
   endfunction

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= ST_ADDR;
         idx           <= '0;
         s_axis_tready <= 1'b0;
         cfg_data      <= '0;
         sts_err       <= '0;
`ifdef AXIS_CFG_WRITER_STROBE_EN
         cfg_strb      <= '0;
`endif
      end else begin
         s_axis_tready <= 1'b1;
`ifdef AXIS_CFG_WRITER_STROBE_EN
         cfg_strb      <= '0;
`endif
         if (beat) begin
            case (state)
               ST_ADDR: begin
                  idx <= s_axis_tdata;
                  if (s_axis_tlast)
                     sts_err <= sat_inc(sts_err);
                  else
                     state <= ST_DATA;
               end
               ST_DATA: begin
                  state <= ST_ADDR;
                  if (in_range) begin
                     for (int k = 0; k < CFG_NUM; k++) begin
                        if (idx_ext == CW'(k)) begin
                           cfg_data[k*W +: W] <= s_axis_tdata;
`ifdef AXIS_CFG_WRITER_STROBE_EN
                           cfg_strb[k] <= 1'b1;
`endif
                        end
                     end
                  end else begin
                     sts_err <= sat_inc(sts_err);
                  end
               end
               default: state <= ST_ADDR;
            endcase
         end
      end
   end

endmodule

// File: doc/axis_cfg_writer.md
Name: axis_cfg_writer

Overview:
- AXI-Stream slave that turns a stream of (index, value) word pairs into a bank of CFG_NUM configuration registers.
- Receive-side counterpart of the change-driven config-to-stream master. It lets a stream source (DMA, CPU FIFO, remote link) drive cfg_data buses that normally come from the memory-mapped config block.
- Malformed or out-of-range pairs are dropped and counted.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of stream words and of each config register.
- CFG_NUM, 4, number of config registers; legal range 1..256.
- ERR_CNTR_WIDTH, 16, width of the saturating error counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  index word or value word.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tlast  in  1  end-of-pair marker; checked only on the index beat.
- s_axis_tready  out  1  slave ready.
- cfg_data  out  CFG_NUM*AXIS_TDATA_WIDTH  flattened register bank; register k occupies bits [k*W +: W].
- sts_err  out  ERR_CNTR_WIDTH  count of dropped pairs or beats.

Behaviour:
- Reset (aresetn low at a rising edge):
  - all cfg registers 0, sts_err 0, state ADDR, stored index 0, s_axis_tready 0.
- s_axis_tready:
  - Registered; reset value 0.
  - Goes 1 on the first edge with aresetn high, then stays 1 (no backpressure).
- Beat accepted: s_axis_tvalid & s_axis_tready at a rising edge. No action on edges without an accepted beat.
- FSM, two states:
  - ADDR, accepted beat:
    - Index register <= s_axis_tdata, taken as a full-width unsigned value.
    - If s_axis_tlast = 1: framing error, sts_err increments, state stays ADDR, index discarded.
    - Otherwise: next state DATA.
  - DATA, accepted beat:
    - If stored index < CFG_NUM: register[index] <= s_axis_tdata. The new value appears on cfg_data one cycle after the accepting edge.
    - Otherwise: value discarded, sts_err increments.
    - Next state ADDR in both cases; s_axis_tlast is ignored.
- Index compare uses the full word, so 0x00000100 with CFG_NUM=4 is out of range. There is no truncation to low bits.
- A write with a value equal to the current contents is still performed (and still strobed when the optional feature is compiled in).
- sts_err saturates at all-ones; at most one increment per accepted beat.
- Gaps (tvalid low) between index and value beats are allowed indefinitely; the FSM holds DATA.
- Reset asserted while in DATA: pending index is discarded, no register write occurs, and the FSM restarts in ADDR.
- Registers not addressed keep their value; only one register can change per cycle.

Optional Feature:
- Macro: AXIS_CFG_WRITER_STROBE_EN.
- Defined:
  - Extra output cfg_strb, width CFG_NUM, reset 0.
  - Bit k pulses high for exactly one cycle, the same cycle the new register[k] value first appears on cfg_data, on every in-range write to k.
  - No pulse on framing or range errors.
- Not defined: port cfg_strb is absent; all other behaviour is identical.

Test Plan:
- Reset release: hold aresetn low 5 cycles, then high -> cfg_data=0 and sts_err=0 throughout; s_axis_tready 0 during reset, 1 from the first edge after release.
- Basic write, CFG_NUM=4: beats 0x2 then 0xDEADBEEF, tlast=1 on the second -> register 2 = 0xDEADBEEF one cycle after the acceptance edge; registers 0, 1, 3 remain 0; sts_err=0.
- Out-of-range: beats 0x4 then 0x12345678, then 0x100 then 0x1 -> no register changes, sts_err=2; following pair 0x0 then 0xA5 -> register 0 = 0xA5.
- Framing: beat 0x1 with tlast=1, then 0x3 (tlast=0) then 0x77 -> sts_err=1, register 1 unchanged, register 3 = 0x77.
- Gapped pair and reset: index 0x1, tvalid low 10 cycles, value 0x55 -> register 1 = 0x55. Then index 0x1, reset pulse, value 0x99 -> 0x99 is treated as an index (out of range on the next value beat), register 1 stays 0 after reset.
- Strobe (AXIS_CFG_WRITER_STROBE_EN): write 0x3 then 0x10 twice back-to-back -> cfg_strb=4'b1000 for one cycle per write, aligned with cfg_data update; an error pair produces no pulse. Also check sts_err saturation with ERR_CNTR_WIDTH=2: 5 errors -> sts_err=3.
